// File: rtl/ps2_mmio_receiver.sv
// PS/2 keyboard receiver: conditions raw lines, deserialises 11-bit frames, buffers bytes for one MMIO word.
// Latency: push 2+FILTER_LEN cycles after the stop-bit falling edge; no backpressure, bytes arriving to a full FIFO are dropped.

module ps2_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdat,
   output logic [WIDTH-1:0]           rdat,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok = push && (!full || pop_ok);
   assign rdat    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr] <= wdat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end
endmodule

module ps2_mmio_receiver #(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        rd_strobe,
   output logic [31:0] data_out,
   output logic        irq_pending
);
   localparam int FW = $clog2(FILTER_LEN+1);
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN-1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES-1);

   typedef enum logic {IDLE, RECV} state_t;

   // Index 0 is the PS/2 clock line, index 1 the data line.
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    filt;
   logic [FW-1:0] fcnt [2];

   logic          bit_event;
   logic          line_data;

   state_t        state;
   state_t        state_next;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] timer;
   logic          timeout;

   logic          push;
   logic          parity_evt;
   logic          frame_evt;
   logic          overflow_evt;
   logic          overflow;
   logic          parity_err;
   logic          frame_err;

   logic [7:0]    head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
      end else begin
         sync1 <= {ps2_data, ps2_clk};
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            filt[i] <= 1'b1;
            fcnt[i] <= '0;
         end else if (sync2[i] == filt[i]) begin
            fcnt[i] <= '0;
         end else if (fcnt[i] == FMAX) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
         end else begin
            fcnt[i] <= fcnt[i] + FW'(1);
         end
      end
   end

   // Flagged in the cycle the filtered clock is about to fall, so the FSM acts on the same edge.
   assign bit_event = filt[0] && !sync2[0] && (fcnt[0] == FMAX);
   assign line_data = filt[1];
   assign timeout   = (state == RECV) && !bit_event && (timer == TMAX);

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bit_event && !line_data) state_next = RECV;
         RECV: if ((bit_event && bit_cnt == 4'd10) || timeout) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      parity_evt = 1'b0;
      frame_evt = 1'b0;
      if (state == RECV) begin
         if (bit_event && bit_cnt == 4'd10) begin
            if (!line_data)
               frame_evt = 1'b1;
            else if (^{shreg, par_bit})
               push = 1'b1;
            else
               parity_evt = 1'b1;
         end else if (timeout) begin
            frame_evt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         timer   <= '0;
      end else if (state == IDLE) begin
         timer <= '0;
         if (bit_event && !line_data)
            bit_cnt <= 4'd1;
      end else if (bit_event) begin
         timer <= '0;
         if (bit_cnt <= 4'd8)
            shreg <= {line_data, shreg[7:1]};
         if (bit_cnt == 4'd9)
            par_bit <= line_data;
         bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end else if (timeout) begin
         timer   <= '0;
         bit_cnt <= '0;
      end else begin
         timer <= timer + TW'(1);
      end
   end

   ps2_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (rd_strobe),
      .wdat  (shreg),
      .rdat  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A full FIFO is never empty, so any read this cycle makes room for the push.
   assign overflow_evt = push && fifo_full && !rd_strobe;

   always_ff @(posedge clock) begin
      if (reset) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         overflow   <= overflow_evt || (overflow   && !rd_strobe);
         parity_err <= parity_evt   || (parity_err && !rd_strobe);
         frame_err  <= frame_evt    || (frame_err  && !rd_strobe);
      end
   end

   assign irq_pending = !fifo_empty;
   assign data_out    = {16'h0000, 4'(fifo_count), frame_err, parity_err, overflow,
                         !fifo_empty, fifo_empty ? 8'h00 : head};
endmodule

// File: tb/tb_ps2_mmio_receiver.sv
// Directed bench for ps2_mmio_receiver: drives PS/2 frames and checks the MMIO word and interrupt.

module tb_ps2_mmio_receiver;
   localparam int FILT = 8;
   localparam int TO   = 1000;
   localparam int HALF = 30;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rd_strobe = 1'b0;
   logic [31:0] data_out;
   logic        irq_pending;

   int checks = 0;
   int errors = 0;

   ps2_mmio_receiver #(.FIFO_DEPTH(8), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rd_strobe   (rd_strobe),
      .data_out    (data_out),
      .irq_pending (irq_pending)
   );

   always #10 clock = ~clock;

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic par);
      return {1'b1, par, d, 1'b0};
   endfunction

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   // Bits lo..hi, LSB first; optionally pulses rd_strobe in the stop-bit event cycle.
   task automatic send_bits(input logic [10:0] bits, input int lo, input int hi, input bit rd_at_stop);
      for (int i = lo; i <= hi; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF/2);
         ps2_clk = 1'b0;
         if (rd_at_stop && i == 10) begin
            wait_cyc(FILT + 1);
            rd_strobe = 1'b1;
            wait_cyc(1);
            rd_strobe = 1'b0;
            wait_cyc(HALF - FILT - 2);
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b1;
         wait_cyc(HALF/2);
      end
      ps2_data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_bits(frame(d, odd_par(d)), 0, 10, 1'b0);
   endtask

   task automatic read_pulse();
      rd_strobe = 1'b1;
      wait_cyc(1);
      rd_strobe = 1'b0;
      wait_cyc(2);
   endtask

   task automatic glitch();
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
   endtask

   initial begin
      wait_cyc(3);
      reset = 1'b0;
      check("reset_data", data_out, 32'h0000_0000);
      check("reset_irq", {31'b0, irq_pending}, 32'd0);
      wait_cyc(20);

      send_bits(frame(8'h1C, 1'b0), 0, 10, 1'b0);
      check("single_byte", data_out, 32'h0000_111C);
      check("single_irq", {31'b0, irq_pending}, 32'd1);
      read_pulse();
      check("single_read", data_out, 32'h0000_0000);
      check("single_irq_clr", {31'b0, irq_pending}, 32'd0);

      send_bits(frame(8'hF0, 1'b0), 0, 10, 1'b0);
      check("parity_err", data_out, 32'h0000_0400);
      read_pulse();
      check("parity_clr", data_out, 32'h0000_0000);

      for (int k = 1; k <= 9; k++) send_byte(8'(k));
      check("overflow", data_out, 32'h0000_8301);
      for (int k = 0; k < 8; k++) begin
         check("drain", data_out,
               32'(((8 - k) << 12) | 32'h100 | (k + 1) | ((k == 0) ? 32'h200 : 32'h0)));
         read_pulse();
      end
      check("drained", data_out, 32'h0000_0000);
      send_byte(8'h0A);
      check("wrap", data_out, 32'h0000_110A);
      read_pulse();
      check("wrap_read", data_out, 32'h0000_0000);

      send_bits(frame(8'h5A, 1'b1), 0, 3, 1'b0);
      wait_cyc(TO + 10);
      check("timeout_flag", data_out, 32'h0000_0800);
      send_bits(frame(8'h5A, 1'b1), 0, 10, 1'b0);
      check("after_timeout", data_out, 32'h0000_195A);
      read_pulse();
      check("timeout_read", data_out, 32'h0000_0000);

      glitch();
      check("glitch_idle", data_out, 32'h0000_0000);
      send_bits(frame(8'h29, 1'b0), 0, 4, 1'b0);
      glitch();
      send_bits(frame(8'h29, 1'b0), 5, 10, 1'b0);
      check("glitch_frame", data_out, 32'h0000_1129);
      read_pulse();
      check("glitch_read", data_out, 32'h0000_0000);

      for (int k = 0; k < 8; k++) send_byte(8'h11 + 8'(k));
      check("full", data_out, 32'h0000_8111);
      send_bits(frame(8'h19, odd_par(8'h19)), 0, 10, 1'b1);
      check("push_pop_full", data_out, 32'h0000_8112);
      for (int k = 0; k < 7; k++) read_pulse();
      check("tail_byte", data_out, 32'h0000_1119);

      send_bits(frame(8'h44, odd_par(8'h44)), 0, 3, 1'b0);
      reset = 1'b1;
      wait_cyc(1);
      reset = 1'b0;
      check("midreset_data", data_out, 32'h0000_0000);
      check("midreset_irq", {31'b0, irq_pending}, 32'd0);
      wait_cyc(TO + 10);
      check("midreset_idle", data_out, 32'h0000_0000);
      send_bits(frame(8'h33, 1'b1), 0, 10, 1'b0);
      check("after_reset", data_out, 32'h0000_1133);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
